// File: rtl/alu_mp_sequencer_pkg.sv
// Shared definitions for the multi-precision ALU sequencer: opcodes, FSM
// state encoding and opcode classification.
package alu_mp_sequencer_pkg;

  localparam logic [2:0] OP_ADD     = 3'b000;
  localparam logic [2:0] OP_SUB     = 3'b001;
  localparam logic [2:0] OP_RSUB    = 3'b010;
  localparam logic [2:0] OP_OR      = 3'b011;
  localparam logic [2:0] OP_AND     = 3'b100;
  localparam logic [2:0] OP_NOTA_OR = 3'b101;
  localparam logic [2:0] OP_XOR     = 3'b110;
  localparam logic [2:0] OP_XNOR    = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_RSUB);
  endfunction

endpackage

// File: rtl/alu_mp_sequencer_alu.sv
// Byte-wide ALU: three carry-aware arithmetic ops and five bitwise logic ops.
// Logic ops always report a carry-out of zero.
module alu_mp_sequencer_alu
  import alu_mp_sequencer_pkg::*;
(
  input  logic [2:0] oper,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_in,
  output logic [7:0] sum,
  output logic       c_out
);

  logic [8:0] wide;

  always_comb begin
    wide = 9'd0;
    case (oper)
      OP_ADD:     wide = {1'b0, a} + {1'b0, b}  + {8'd0, c_in};
      OP_SUB:     wide = {1'b0, a} + {1'b0, ~b} + {8'd0, c_in};
      // Reverse subtract consumes an inverted carry-in.
      OP_RSUB:    wide = {1'b0, b} + {1'b0, ~a} + {8'd0, ~c_in};
      OP_OR:      wide = {1'b0, a | b};
      OP_AND:     wide = {1'b0, a & b};
      OP_NOTA_OR: wide = {1'b0, ~a | b};
      OP_XOR:     wide = {1'b0, a ^ b};
      OP_XNOR:    wide = {1'b0, ~(a ^ b)};
      default:    wide = 9'd0;
    endcase
    sum   = wide[7:0];
    c_out = wide[8];
  end

endmodule

// File: rtl/alu_mp_sequencer.sv
// Runs an NBYTES-wide operation through one byte-wide ALU, LSB first,
// chaining the registered carry between bytes for arithmetic opcodes.
module alu_mp_sequencer
  import alu_mp_sequencer_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            oper,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  c_in,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  c_out,
  output logic                  zero
);

  localparam int W     = 8 * NBYTES;
  localparam int IDX_W = $clog2(NBYTES) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t           state;
  state_t           next_state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic [2:0]       oper_r;
  logic             c_in_r;

  logic [7:0]       a_byte;
  logic [7:0]       b_byte;
  logic [7:0]       alu_sum;
  logic             alu_c_in;
  logic             alu_c_out;
  logic [W-1:0]     next_result;
  logic             accept;
  logic             last_byte;

  // Handshake: start is a request that is taken only while busy is low; a
  // request seen while busy is dropped, there is no queueing.
  assign accept    = (state == ST_IDLE) && start;
  assign last_byte = (state == ST_RUN) && (idx == LAST_IDX);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start) next_state = ST_RUN;
      ST_RUN:  if (idx == LAST_IDX) next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    a_byte = 8'd0;
    b_byte = 8'd0;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx == IDX_W'(i)) begin
        a_byte = a_r[8*i +: 8];
        b_byte = b_r[8*i +: 8];
      end
    end
  end

  // Byte 0 takes the caller's carry verbatim; later bytes re-present the
  // previous carry so that the ALU's own inversion for RSUB cancels out.
  always_comb begin
    alu_c_in = 1'b0;
    if (idx == '0) begin
      alu_c_in = c_in_r;
    end else begin
      case (oper_r)
        OP_ADD, OP_SUB: alu_c_in = carry;
        OP_RSUB:        alu_c_in = ~carry;
        default:        alu_c_in = 1'b0;
      endcase
    end
  end

  alu_mp_sequencer_alu u_alu (
    .oper  (oper_r),
    .a     (a_byte),
    .b     (b_byte),
    .c_in  (alu_c_in),
    .sum   (alu_sum),
    .c_out (alu_c_out)
  );

  always_comb begin
    next_result = result;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx == IDX_W'(i)) next_result[8*i +: 8] = alu_sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      carry  <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      oper_r <= 3'd0;
      c_in_r <= 1'b0;
      result <= '0;
      c_out  <= 1'b0;
      zero   <= 1'b0;
    end else if (accept) begin
      idx    <= '0;
      carry  <= 1'b0;
      a_r    <= a;
      b_r    <= b;
      oper_r <= oper;
      c_in_r <= c_in;
      result <= '0;
      c_out  <= 1'b0;
      zero   <= 1'b0;
    end else if (state == ST_RUN) begin
      result <= next_result;
      carry  <= alu_c_out;
      idx    <= idx + 1'b1;
      if (last_byte) begin
        c_out <= is_arith(oper_r) & alu_c_out;
        zero  <= (next_result == '0);
      end
    end
  end

endmodule
